lcd_refresh_driver: RTL and testbench

- HD44780-style 16x2 character LCD bus driver, 8-bit mode, write-only.
- Sits directly downstream of the character list stage (index -> registered ASCII byte, one-cycle latency).
- After power-up it runs the init command sequence. It then refreshes both lines forever: it drives `index` 0..31, fetches each character and writes it with correctly timed RS/E strobes.

---
 rtl/lcd_pkg.sv | 66 ++++++
 rtl/lcd_strobe_timer.sv | 81 ++++++++
 rtl/lcd_refresh_driver.sv | 141 ++++++++++++++
 tb/tb_lcd_refresh_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: command bytes, write-sequence map and FSM encodings
// shared by the HD44780 refresh driver and its strobe timer.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   localparam logic [5:0] SEQ_CLEAR = 6'd3;
   localparam logic [5:0] SEQ_LINE1 = 6'd4;
   localparam logic [5:0] SEQ_DATA0 = 6'd5;
   localparam logic [5:0] SEQ_LINE2 = 6'd21;
   localparam logic [5:0] SEQ_LAST  = 6'd37;

   localparam int CNT_W_MIN = 20;

   typedef enum logic [1:0] {
      TOP_POWERUP,
      TOP_LOAD,
      TOP_STROBE
   } top_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_EHIGH,
      PH_WAIT
   } phase_e;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int cnt_width(input int maxv);
      return imax($clog2(maxv + 1), CNT_W_MIN);
   endfunction

   function automatic logic seq_is_data(input logic [5:0] seq);
      return (seq >= SEQ_DATA0) && (seq != SEQ_LINE2);
   endfunction

   // Line 2 slots sit one step later because of the 0xC0 address write.
   function automatic logic [4:0] seq_slot(input logic [5:0] seq);
      if (seq < SEQ_LINE2)
         return 5'(seq - SEQ_DATA0);
      return 5'(seq - 6'd6);
   endfunction

   function automatic logic [7:0] seq_cmd(input logic [5:0] seq);
      logic [7:0] c;
      c = CMD_LINE1;
      case (seq)
         6'd0:      c = CMD_FUNC_SET;
         6'd1:      c = CMD_DISP_ON;
         6'd2:      c = CMD_ENTRY;
         SEQ_CLEAR: c = CMD_CLEAR;
         SEQ_LINE2: c = CMD_LINE2;
         default:   c = CMD_LINE1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// lcd_strobe_timer: one bus write -- setup with E low, E high pulse,
// then a post-strobe wait whose length is chosen by the caller.
module lcd_strobe_timer
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC  = 5,
   parameter int E_HIGH_CYC = 25,
   parameter int CNT_W      = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [CNT_W-1:0] wait_len_i,
   output logic             done_o,
   output logic             lcd_e_o
);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYC - 1);

   phase_e           ph_q, ph_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             e_q, e_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q  <= PH_IDLE;
         cnt_q <= '0;
         e_q   <= 1'b0;
      end else begin
         ph_q  <= ph_d;
         cnt_q <= cnt_d;
         e_q   <= e_d;
      end
   end

   always_comb begin
      ph_d   = ph_q;
      cnt_d  = cnt_q;
      e_d    = e_q;
      done_o = 1'b0;
      unique case (ph_q)
         PH_IDLE: begin
            if (start_i) begin
               ph_d  = PH_SETUP;
               cnt_d = SETUP_LD;
            end
         end
         PH_SETUP: begin
            if (cnt_q == '0) begin
               ph_d  = PH_EHIGH;
               cnt_d = EHIGH_LD;
               e_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PH_EHIGH: begin
            if (cnt_q == '0) begin
               ph_d  = PH_WAIT;
               cnt_d = wait_len_i - 1'b1;
               e_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PH_WAIT: begin
            if (cnt_q == '0) begin
               ph_d   = PH_IDLE;
               done_o = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: ph_d = PH_IDLE;
      endcase
   end

   assign lcd_e_o = e_q;

endmodule

// File: rtl/lcd_refresh_driver.sv
// lcd_refresh_driver: HD44780 16x2 init sequence followed by an
// endless two-line refresh fed from the character list stage.
module lcd_refresh_driver
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYC = 750000,
   parameter int SETUP_CYC   = 5,
   parameter int E_HIGH_CYC  = 25,
   parameter int WAIT_CYC    = 2500,
   parameter int CLEAR_CYC   = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_in,
   output logic [4:0] index,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       init_done,
   output logic       frame_done
);

   localparam int MAX_CYC = imax(imax(POWERUP_CYC, SETUP_CYC),
                                 imax(imax(E_HIGH_CYC, WAIT_CYC),
                                      CLEAR_CYC));
   localparam int CNT_W = cnt_width(MAX_CYC);

   localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LEN  = CNT_W'(WAIT_CYC);
   localparam logic [CNT_W-1:0] CLEAR_LEN = CNT_W'(CLEAR_CYC);

   top_e             st_q, st_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [1:0]       lcnt_q, lcnt_d;
   logic [5:0]       seq_q, seq_d;
   logic [4:0]       idx_q, idx_d;
   logic [7:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             init_q, init_d;
   logic             frame_q, frame_d;
   logic             start;
   logic             done;
   logic             is_data;
   logic [CNT_W-1:0] wait_len;

   assign is_data  = seq_is_data(seq_q);
   assign wait_len = (seq_q == SEQ_CLEAR) ? CLEAR_LEN : WAIT_LEN;

   lcd_strobe_timer #(
      .SETUP_CYC  (SETUP_CYC),
      .E_HIGH_CYC (E_HIGH_CYC),
      .CNT_W      (CNT_W)
   ) u_strobe (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start),
      .wait_len_i (wait_len),
      .done_o     (done),
      .lcd_e_o    (lcd_e)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= TOP_POWERUP;
         pcnt_q  <= '0;
         lcnt_q  <= '0;
         seq_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         rs_q    <= 1'b0;
         init_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         pcnt_q  <= pcnt_d;
         lcnt_q  <= lcnt_d;
         seq_q   <= seq_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         init_q  <= init_d;
         frame_q <= frame_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      pcnt_d  = pcnt_q;
      lcnt_d  = lcnt_q;
      seq_d   = seq_q;
      idx_d   = idx_q;
      data_d  = data_q;
      rs_d    = rs_q;
      init_d  = init_q;
      frame_d = 1'b0;
      start   = 1'b0;
      unique case (st_q)
         TOP_POWERUP: begin
            if (pcnt_q == PWR_LAST) begin
               st_d   = TOP_LOAD;
               lcnt_d = '0;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         TOP_LOAD: begin
            lcnt_d = lcnt_q + 2'd1;
            if (lcnt_q == 2'd0 && is_data)
               idx_d = seq_slot(seq_q);
            // char_in reflects the new index only by the third cycle.
            if (lcnt_q == 2'd2) begin
               start  = 1'b1;
               lcnt_d = '0;
               st_d   = TOP_STROBE;
               rs_d   = is_data;
               data_d = is_data ? char_in : seq_cmd(seq_q);
            end
         end
         TOP_STROBE: begin
            if (done) begin
               st_d    = TOP_LOAD;
               seq_d   = (seq_q == SEQ_LAST) ? SEQ_LINE1
                                             : seq_q + 6'd1;
               frame_d = (seq_q == SEQ_LAST);
               if (seq_q == SEQ_CLEAR)
                  init_d = 1'b1;
            end
         end
         default: st_d = TOP_POWERUP;
      endcase
   end

   assign index      = idx_q;
   assign lcd_rs     = rs_q;
   assign lcd_rw     = 1'b0;
   assign lcd_data   = data_q;
   assign init_done  = init_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_lcd_refresh_driver.sv
// tb_lcd_refresh_driver: timeline model of the LCD bus compared every
// cycle, with a noisy character source and a mid-strobe reset.
module tb_lcd_refresh_driver;

   localparam int POW = 20;
   localparam int SET = 2;
   localparam int EH  = 3;
   localparam int WT  = 5;
   localparam int CLR = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] char_in;
   logic [4:0] index;
   logic       lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;
   logic       init_done, frame_done;

   lcd_refresh_driver #(
      .POWERUP_CYC (POW),
      .SETUP_CYC   (SET),
      .E_HIGH_CYC  (EH),
      .WAIT_CYC    (WT),
      .CLEAR_CYC   (CLR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .index      (index),
      .lcd_e      (lcd_e),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_data   (lcd_data),
      .init_done  (init_done),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Character list stage: registered 0x40+index, plus noise injection
   logic [7:0] char_q = 8'h00;
   logic [7:0] noise_v = 8'h00;
   logic       noisy = 1'b0;

   always @(posedge clk) begin
      char_q  <= 8'h40 + {3'b000, index};
      noise_v <= 8'($urandom);
   end

   assign char_in = noisy ? noise_v : char_q;

   // Expected outputs
   logic [4:0] ex_idx = '0;
   logic       ex_e = 1'b0, ex_rs = 1'b0;
   logic [7:0] ex_data = '0;
   logic       ex_init = 1'b0, ex_frame = 1'b0;
   logic       chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h",
                  nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("index", 32'(index), 32'(ex_idx));
         chk("lcd_e", 32'(lcd_e), 32'(ex_e));
         chk("lcd_rs", 32'(lcd_rs), 32'(ex_rs));
         chk("lcd_rw", 32'(lcd_rw), 32'd0);
         chk("lcd_data", 32'(lcd_data), 32'(ex_data));
         chk("init_done", 32'(init_done), 32'(ex_init));
         chk("frame_done", 32'(frame_done), 32'(ex_frame));
      end
   end

   // Event recorder used for the literal pins
   bit rec = 1'b0;
   int cyc = 0;
   logic e_prev = 1'b0, init_prev = 1'b0;
   int rise_t[$];
   int rise_d[$];
   int frame_t[$];
   int init_t = -1;

   always @(negedge clk) begin
      if (rst) begin
         cyc = 0;
      end else begin
         if (rec && lcd_e === 1'b1 && e_prev !== 1'b1) begin
            rise_t.push_back(cyc);
            rise_d.push_back(int'({lcd_rs, lcd_data}));
         end
         if (rec && frame_done === 1'b1)
            frame_t.push_back(cyc);
         if (rec && init_done === 1'b1 && init_prev !== 1'b1)
            init_t = cyc;
         cyc++;
      end
      e_prev    = lcd_e;
      init_prev = init_done;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] cmd_byte(input int s);
      case (s)
         0:       return 8'h38;
         1:       return 8'h0C;
         2:       return 8'h06;
         3:       return 8'h01;
         21:      return 8'hC0;
         default: return 8'h80;
      endcase
   endfunction

   task automatic zero_exp();
      ex_idx   = '0;
      ex_e     = 1'b0;
      ex_rs    = 1'b0;
      ex_data  = '0;
      ex_init  = 1'b0;
      ex_frame = 1'b0;
      noisy    = 1'b0;
   endtask

   // Called one step after the edge that ends reset; walks the bus
   // timeline write by write. With cut set, returns inside the
   // second E-high cycle of the last write.
   task automatic run_model(input int nwr, input bit cut);
      int  s;
      bit  dat;
      int  slot;
      s = 0;
      zero_exp();
      tick(POW);
      for (int w = 0; w < nwr; w++) begin
         dat  = (s >= 5) && (s != 21);
         slot = (s < 21) ? s - 5 : s - 6;
         tick(1);
         ex_frame = 1'b0;
         if (dat)
            ex_idx = 5'(slot);
         tick(2);
         ex_data = dat ? 8'(8'h40 + slot) : cmd_byte(s);
         ex_rs   = dat;
         noisy   = 1'b1;
         tick(SET);
         ex_e = 1'b1;
         if (cut && w == nwr - 1) begin
            tick(1);
            return;
         end
         tick(EH);
         ex_e = 1'b0;
         tick((s == 3) ? CLR : WT);
         noisy = 1'b0;
         if (s == 3)
            ex_init = 1'b1;
         if (s == 37)
            ex_frame = 1'b1;
         s = (s == 37) ? 4 : s + 1;
      end
   endtask

   task automatic clear_rec();
      rise_t.delete();
      rise_d.delete();
      frame_t.delete();
      init_t = -1;
   endtask

   initial begin
      int cut_w;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      rec    = 1'b1;
      run_model(75, 1'b0);
      rec = 1'b0;

      chk("first_rise_cycle", 32'(rise_t[0]), 32'd25);
      chk("rise_count", 32'(rise_t.size()), 32'd75);
      chk("wr0_cmd", 32'(rise_d[0]), 32'h038);
      chk("wr1_cmd", 32'(rise_d[1]), 32'h00C);
      chk("wr2_cmd", 32'(rise_d[2]), 32'h006);
      chk("wr3_cmd", 32'(rise_d[3]), 32'h001);
      chk("wr4_line1", 32'(rise_d[4]), 32'h080);
      chk("wr5_char0", 32'(rise_d[5]), 32'h140);
      chk("wr20_char15", 32'(rise_d[20]), 32'h14F);
      chk("wr21_line2", 32'(rise_d[21]), 32'h0C0);
      chk("wr22_char16", 32'(rise_d[22]), 32'h150);
      chk("wr37_char31", 32'(rise_d[37]), 32'h15F);
      chk("wr38_line1_again", 32'(rise_d[38]), 32'h080);
      chk("wr39_char0_again", 32'(rise_d[39]), 32'h140);
      chk("gap_normal", 32'(rise_t[3] - rise_t[2]), 32'd13);
      chk("gap_clear", 32'(rise_t[4] - rise_t[3]), 32'd18);
      chk("init_rise_cycle", 32'(init_t), 32'd77);
      chk("frame_count", 32'(frame_t.size()), 32'd2);
      chk("frame_first", 32'(frame_t[0]), 32'd519);
      chk("frame_interval", 32'(frame_t[1] - frame_t[0]), 32'd442);

      // Reset during E high, then the whole init replays
      cut_w = $urandom_range(5, 60);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_model(cut_w, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      zero_exp();
      #1;
      rst = 1'b0;
      chk("reset_drops_e", 32'(lcd_e), 32'd0);
      chk("reset_drops_init", 32'(init_done), 32'd0);
      clear_rec();
      rec = 1'b1;
      run_model(8, 1'b0);
      rec = 1'b0;
      chk("replay_first_rise", 32'(rise_t[0]), 32'd25);
      chk("replay_wr0", 32'(rise_d[0]), 32'h038);
      chk("replay_wr3", 32'(rise_d[3]), 32'h001);
      chk("replay_wr5", 32'(rise_d[5]), 32'h140);
      chk("replay_wr7", 32'(rise_d[7]), 32'h142);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
